// File: rtl/deser_pkg.sv
// deser_pkg: shared constants and types for the rx deserializer/aligner and
// for the K-flag logic in recibidor.
package deser_pkg;

    // K28.5 comma in both running disparities, bit 'a' at [9]
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        ALIGN  = 2'd1,
        SYNC   = 2'd2
    } syncState_t;

    // one registered output event of the aligner
    typedef struct packed {
        logic [9:0] sym;
        logic       valid;
        logic       comma;
        logic       alignErr;
    } symEvt_t;

endpackage

// File: rtl/deser_comma_det.sv
// deser_comma_det: combinational K28.5 detector (either disparity).
module deser_comma_det
    import deser_pkg::*;
(
    input  logic [9:0] sym,
    output logic       comma
);

    assign comma = (sym == K28_5_RDN) || (sym == K28_5_RDP);

endmodule

// File: rtl/deserializador_alineador.sv
// deserializador_alineador: shifts serialIn into 10-bit symbols, aligns the
// symbol boundary on K28.5 commas and runs the UNSYNC/ALIGN/SYNC machine.
// Optional electrical-idle detection is built when DESER_IDLE_DET_EN is
// defined; otherwise rxElecIdle is tied low.
module deserializador_alineador
    import deser_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int IDLE_LEN = 20
) (
    input  logic       clkRx,
    input  logic       rst,
    input  logic       enb,
    input  logic       serialIn,
    output logic [9:0] symOut,
    output logic       symValid,
    output logic       commaDet,
    output logic       syncOk,
    output logic       alignErr,
    output logic       rxElecIdle
);

    logic [9:0] sh;
    logic [9:0] shN;
    logic [3:0] cnt;
    logic       wrap;
    logic       comma;
    logic       idleN;
    syncState_t state;
    logic [7:0] goodCnt;
    logic [7:0] badCnt;
    symEvt_t    evt;

    assign shN  = {sh[8:0], serialIn};
    // cnt==9 means this bit completes a symbol on the current phase
    assign wrap = (cnt == 4'd9);

    deser_comma_det uCommaDet (
        .sym   (shN),
        .comma (comma)
    );

`ifdef DESER_IDLE_DET_EN
    localparam int RW = $clog2(IDLE_LEN + 1);

    logic [RW-1:0] runCnt;
    logic [RW-1:0] runN;
    logic          lastBit;

    // length of the current constant-bit run, saturating at IDLE_LEN
    always_comb begin
        runN = RW'(1);
        if ((runCnt != '0) && (serialIn == lastBit))
            runN = (runCnt == RW'(IDLE_LEN)) ? runCnt : runCnt + RW'(1);
    end

    assign idleN = (runN == RW'(IDLE_LEN));

    // run tracking; idle flag follows the run one cycle later
    always_ff @(posedge clkRx) begin
        if (!rst) begin
            runCnt     <= '0;
            lastBit    <= 1'b0;
            rxElecIdle <= 1'b0;
        end else if (enb) begin
            runCnt     <= runN;
            lastBit    <= serialIn;
            rxElecIdle <= idleN;
        end
    end
`else
    assign idleN      = 1'b0;
    assign rxElecIdle = 1'b0;
`endif

    assign symOut   = evt.sym;
    assign symValid = evt.valid;
    assign commaDet = evt.comma;
    assign alignErr = evt.alignErr;

    // shift/phase tracking plus the sync state machine; all outputs registered
    always_ff @(posedge clkRx) begin
        if (!rst) begin
            sh      <= '0;
            cnt     <= '0;
            state   <= UNSYNC;
            goodCnt <= '0;
            badCnt  <= '0;
            evt     <= '0;
            syncOk  <= 1'b0;
        end else begin
            evt.valid    <= 1'b0;
            evt.comma    <= 1'b0;
            evt.alignErr <= 1'b0;
            if (enb) begin
                sh  <= shN;
                cnt <= wrap ? 4'd0 : cnt + 4'd1;
                if (idleN) begin
                    // idle line: drop sync and emit nothing
                    state   <= UNSYNC;
                    syncOk  <= 1'b0;
                    goodCnt <= '0;
                    badCnt  <= '0;
                end else begin
                    case (state)
                        UNSYNC: begin
                            if (comma) begin
                                evt.sym   <= shN;
                                evt.valid <= 1'b1;
                                evt.comma <= 1'b1;
                                cnt       <= 4'd0;
                                goodCnt   <= 8'd1;
                                if (LOCK_CNT <= 1) begin
                                    state  <= SYNC;
                                    syncOk <= 1'b1;
                                end else begin
                                    state <= ALIGN;
                                end
                            end
                        end
                        ALIGN: begin
                            if (comma && !wrap) begin
                                // off-phase comma while acquiring: realign on it
                                evt.sym      <= shN;
                                evt.valid    <= 1'b1;
                                evt.comma    <= 1'b1;
                                evt.alignErr <= 1'b1;
                                cnt          <= 4'd0;
                                goodCnt      <= 8'd1;
                                if (LOCK_CNT <= 1) begin
                                    state  <= SYNC;
                                    syncOk <= 1'b1;
                                end
                            end else if (wrap) begin
                                evt.sym   <= shN;
                                evt.valid <= 1'b1;
                                evt.comma <= comma;
                                if (comma) begin
                                    goodCnt <= goodCnt + 8'd1;
                                    if (goodCnt + 8'd1 >= 8'(LOCK_CNT)) begin
                                        state  <= SYNC;
                                        syncOk <= 1'b1;
                                        badCnt <= '0;
                                    end
                                end
                            end
                        end
                        SYNC: begin
                            if (wrap) begin
                                evt.sym   <= shN;
                                evt.valid <= 1'b1;
                                evt.comma <= comma;
                                if (comma)
                                    badCnt <= '0;
                            end
                            if (comma && !wrap) begin
                                // locked phase is kept; only count the offence
                                evt.alignErr <= 1'b1;
                                if (badCnt + 8'd1 >= 8'(LOSS_CNT)) begin
                                    state   <= UNSYNC;
                                    syncOk  <= 1'b0;
                                    goodCnt <= '0;
                                    badCnt  <= '0;
                                end else begin
                                    badCnt <= badCnt + 8'd1;
                                end
                            end
                        end
                        default: begin
                            state  <= UNSYNC;
                            syncOk <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_deserializador_alineador.sv
// tb_deserializador_alineador: directed stimulus with a scoreboard queue of
// expected output events, popped by an independent monitor.
module tb_deserializador_alineador;

    typedef struct packed {
        logic [9:0] sym;
        logic       vld;
        logic       cd;
        logic       ae;
        logic       so;
    } evt_t;

    logic       clkRx = 1'b0;
    logic       rst = 1'b0;
    logic       enb = 1'b1;
    logic       serialIn = 1'b1;
    logic [9:0] symOut;
    logic       symValid, commaDet, syncOk, alignErr, rxElecIdle;

    int   checks = 0;
    int   failures = 0;
    evt_t q[$];
    evt_t act, ex;

    localparam logic [9:0] RDN  = 10'b0011111010;
    localparam logic [9:0] RDP  = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;

    deserializador_alineador dut (
        .clkRx      (clkRx),
        .rst        (rst),
        .enb        (enb),
        .serialIn   (serialIn),
        .symOut     (symOut),
        .symValid   (symValid),
        .commaDet   (commaDet),
        .syncOk     (syncOk),
        .alignErr   (alignErr),
        .rxElecIdle (rxElecIdle)
    );

    always #5 clkRx = ~clkRx;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // monitor: every output event must match the head of the queue
    always @(negedge clkRx) begin
        if (symValid || alignErr || commaDet) begin
            act = '{symOut, symValid, commaDet, alignErr, syncOk};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got sym=%h vld=%b cd=%b ae=%b so=%b",
                         act.sym, act.vld, act.cd, act.ae, act.so);
            end else begin
                ex = q.pop_front();
                if (act !== ex) begin
                    failures++;
                    $display("FAIL event got sym=%h vld=%b cd=%b ae=%b so=%b want sym=%h vld=%b cd=%b ae=%b so=%b",
                             act.sym, act.vld, act.cd, act.ae, act.so,
                             ex.sym, ex.vld, ex.cd, ex.ae, ex.so);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expectEvt(input logic [9:0] s, input logic v, input logic c,
                             input logic a, input logic so);
        q.push_back('{s, v, c, a, so});
    endtask

    task automatic sendBit(input logic b);
        serialIn = b;
        @(posedge clkRx);
        #1;
    endtask

    task automatic sendBits(input logic [19:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            sendBit(v[i]);
    endtask

    task automatic doReset();
        rst = 1'b0;
        enb = 1'b1;
        repeat (3) sendBit(1'b1);
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        @(negedge clkRx);
        #1;
        chk(name, q.size(), 0);
    endtask

    task automatic lockUp();
        expectEvt(RDN, 1, 1, 0, 0);
        expectEvt(RDP, 1, 1, 0, 0);
        expectEvt(RDN, 1, 1, 0, 0);
        expectEvt(RDP, 1, 1, 0, 1);
        sendBits(RDN, 10);
        sendBits(RDP, 10);
        sendBits(RDN, 10);
        sendBits(RDP, 10);
    endtask

    initial begin
        // 1: reset with serialIn high
        doReset();
        chk("rst_symOut", symOut, 0);
        chk("rst_symValid", symValid, 0);
        chk("rst_commaDet", commaDet, 0);
        chk("rst_syncOk", syncOk, 0);
        chk("rst_alignErr", alignErr, 0);
        chk("rst_rxElecIdle", rxElecIdle, 0);

        // 2: 7 junk bits, comma at bit 17, then D21.5
        sendBits(7'b1010110, 7);
        chk("unsync_no_emit", symValid, 0);
        expectEvt(10'h0FA, 1, 1, 0, 0);
        expectEvt(10'h2AA, 1, 0, 0, 0);
        sendBits(RDN, 10);
        sendBits(D215, 10);
        drain("t2_drain");
        chk("t2_syncOk", syncOk, 0);

        // 3: four aligned commas lock
        doReset();
        lockUp();
        chk("t3_syncOk", syncOk, 1);
        drain("t3_drain");

        // 4: four commas shifted by 3 bits in SYNC
        for (int k = 1; k <= 4; k++) begin
            expectEvt(10'h29F, 1, 0, 0, 1);
            expectEvt(10'h29F, 0, 0, 1, (k < 4) ? 1'b1 : 1'b0);
            if (k < 4)
                expectEvt(10'h12A, 1, 0, 0, 1);
            sendBits(3'b101, 3);
            sendBits(RDN, 10);
            sendBits(7'b0101010, 7);
        end
        chk("t4_syncOk_lost", syncOk, 0);
        drain("t4_drain");

        // 5: enb low mid-symbol, then reset mid-symbol
        doReset();
        expectEvt(10'h0FA, 1, 1, 0, 0);
        sendBits(RDN, 10);
        sendBits(6'b101010, 6);
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sendBit(1'($urandom_range(0, 1)));
            chk("t5_hold", {symOut, symValid, commaDet, alignErr, syncOk},
                {10'h0FA, 4'b0000});
        end
        enb = 1'b1;
        expectEvt(10'h2AA, 1, 0, 0, 0);
        sendBits(4'b1010, 4);
        drain("t5_drain");
        sendBits(5'b10101, 5);
        rst = 1'b0;
        sendBit(1'b0);
        rst = 1'b1;
        chk("t5_rst_symOut", symOut, 0);
        sendBits(5'b01010, 5);
        drain("t5_rst_drain");

        // 6: long zero run while locked
        doReset();
        lockUp();
        expectEvt(10'h000, 1, 0, 0, 1);
`ifdef DESER_IDLE_DET_EN
        sendBits(20'h00000, 20);
        chk("t6_idle_set", rxElecIdle, 1);
        chk("t6_idle_sync", syncOk, 0);
        sendBit(1'b1);
        chk("t6_idle_clear", rxElecIdle, 0);
`else
        expectEvt(10'h000, 1, 0, 0, 1);
        sendBits(20'h00000, 20);
        chk("t6_no_idle", rxElecIdle, 0);
        chk("t6_sync_kept", syncOk, 1);
`endif
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
